// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: registered one-hot grant plus address- and data-phase owner indices.
// Latency: a grant changes one cycle after the arbitration-point edge; HMASTER and HMASTER_D lag by accepted beats.
// Backpressure: HREADY=0 freezes the burst counter, grant, owner indices and lock flag.
// Build option: define AHB_ARB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_D,
    output logic                   HMASTLOCK
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [3:0]             beats_left;
    logic [3:0]             beats_nxt;
    logic [MW-1:0]          g;
    logic [MW-1:0]          winner;
    logic                   any_req;
    logic                   arb_point;
    logic [NUM_MASTERS-1:0] grant_nxt;

    // Remaining beats after the first one of a fixed-length burst.
    function automatic logic [3:0] burst_last(input logic [2:0] hb);
        logic [3:0] res;
        case (hb)
            3'b010, 3'b011: res = 4'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: res = 4'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: res = 4'd15;  // WRAP16 / INCR16
            default:        res = 4'd0;   // SINGLE / INCR (no hold)
        endcase
        return res;
    endfunction

    // Binary owner index from the one-hot grant register.
    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) g = g | MW'(i);
        end
    end

    // Post-update burst counter for this cycle; it moves only on accepted cycles.
    always_comb begin
        beats_nxt = beats_left;
        if (HREADY) begin
            case (HTRANS)
                TR_NONSEQ: beats_nxt = burst_last(HBURST);
                TR_SEQ:    beats_nxt = (beats_left == 4'd0) ? 4'd0 : beats_left - 4'd1;
                TR_IDLE:   beats_nxt = 4'd0;
                default:   beats_nxt = beats_left;   // BUSY keeps the burst position
            endcase
        end
    end

    assign any_req   = |HBUSREQ;
    assign arb_point = HREADY && (beats_nxt == 4'd0) && !HLOCK[g];

`ifdef AHB_ARB_RR_EN
    logic [MW-1:0] ptr;
    logic [MW-1:0] hi_idx;
    logic [MW-1:0] lo_idx;
    logic          hi_found;

    // Cyclic search from ptr: lowest requester at or above ptr, else wrap to lowest overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) begin
                lo_idx = MW'(i);
                if (MW'(i) >= ptr) begin
                    hi_idx   = MW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    // Rotate the search start past the winner; idle arbitration leaves it alone.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr <= '0;
        end else if (arb_point && any_req) begin
            ptr <= (winner == MW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) winner = MW'(i);
        end
    end
`endif

    assign grant_nxt = any_req ? (NUM_MASTERS'(1) << winner) : DEF_GRANT;

    // Grant, burst counter and owner pipeline; everything holds while HREADY is low.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT     <= DEF_GRANT;
            HMASTER    <= DEF_IDX;
            HMASTER_D  <= DEF_IDX;
            HMASTLOCK  <= 1'b0;
            beats_left <= 4'd0;
        end else begin
            beats_left <= beats_nxt;
            if (arb_point) begin
                HGRANT <= grant_nxt;
            end
            if (HREADY) begin
                HMASTER   <= g;
                HMASTER_D <= HMASTER;
                HMASTLOCK <= HLOCK[g];
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: reset, arbitration order, burst hold,
// wait states, lock, early termination and asynchronous reset mid-burst.
`timescale 1ns/1ps
module tb_ahb_rr_arbiter;

    localparam int N = 4;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic [1:0]   HMASTER_D;
    logic         HMASTLOCK;

    int total = 0;
    int bad   = 0;

    ahb_rr_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTER_D(HMASTER_D),
        .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] gr,
                             input logic [1:0] m, input logic [1:0] md);
        chk({tag, ".grant"}, 32'(HGRANT), 32'(gr));
        chk({tag, ".hmaster"}, 32'(HMASTER), 32'(m));
        chk({tag, ".hmaster_d"}, 32'(HMASTER_D), 32'(md));
    endtask

    // One clock edge; outputs are settled 1 ns later and new inputs go in there.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HREADY  = 1'b1;

        // Reset values
        #12;
        chk_state("reset", 4'b0001, 2'd0, 2'd0);
        chk("reset.lock", 32'(HMASTLOCK), 32'd0);

        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        step();
        chk_state("idle", 4'b0001, 2'd0, 2'd0);

`ifdef AHB_ARB_RR_EN
        // All four request: rotate one master per cycle
        HBUSREQ = 4'b1111;
        begin
            logic [3:0] exp_g [5];
            logic [1:0] exp_m [5];
            exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_m = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
            for (int k = 0; k < 5; k++) begin
                step();
                chk($sformatf("rr%0d.grant", k), 32'(HGRANT), 32'(exp_g[k]));
                chk($sformatf("rr%0d.hmaster", k), 32'(HMASTER), 32'(exp_m[k]));
            end
        end
`else
        // Fixed priority: lowest requester keeps winning
        HBUSREQ = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("fp%0d.grant", k), 32'(HGRANT), 32'h2);
        end
        chk("fp.hmaster", 32'(HMASTER), 32'd1);
`endif

        // No requests: back to the default master
        HBUSREQ = 4'b0000;
        step();
        chk("dflt.grant", 32'(HGRANT), 32'h1);
        step();
        step();
        chk_state("dflt", 4'b0001, 2'd0, 2'd0);

        // Burst hold: M1 runs INCR4 while M2 requests
        HBUSREQ = 4'b0010;
        step();
        chk("bh_take.grant", 32'(HGRANT), 32'h2);
        HBUSREQ = 4'b0100;
        HTRANS  = 2'b10;
        HBURST  = 3'b011;
        step();
        chk_state("bh_b1", 4'b0010, 2'd1, 2'd0);
        HTRANS = 2'b11;
        step();
        chk_state("bh_b2", 4'b0010, 2'd1, 2'd1);
        step();
        chk("bh_b3.grant", 32'(HGRANT), 32'h2);
        step();
        chk_state("bh_b4", 4'b0100, 2'd1, 2'd1);

        // Wait states on beat 2 of a WRAP4 by M2 while M3 requests
        HBUSREQ = 4'b1000;
        HTRANS  = 2'b10;
        HBURST  = 3'b010;
        step();
        chk_state("ws_b1", 4'b0100, 2'd2, 2'd1);
        HTRANS = 2'b11;
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_state($sformatf("ws_wait%0d", k), 4'b0100, 2'd2, 2'd1);
        end
        HREADY = 1'b1;
        step();
        chk_state("ws_b2", 4'b0100, 2'd2, 2'd2);
        step();
        chk("ws_b3.grant", 32'(HGRANT), 32'h4);
        step();
        chk("ws_b4.grant", 32'(HGRANT), 32'h8);

        // Lock: M2 holds the bus through SINGLE transfers despite other requests
        HTRANS  = 2'b00;
        HBUSREQ = 4'b0100;
        step();
        chk("lk_take.grant", 32'(HGRANT), 32'h4);
        HLOCK   = 4'b0100;
        HBUSREQ = 4'b1111;
        HTRANS  = 2'b10;
        HBURST  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("lk%0d.grant", k), 32'(HGRANT), 32'h4);
            chk($sformatf("lk%0d.mastlock", k), 32'(HMASTLOCK), 32'd1);
        end
        HLOCK = 4'b0000;
        step();
`ifdef AHB_ARB_RR_EN
        chk("lk_rel.grant", 32'(HGRANT), 32'h8);
`else
        chk("lk_rel.grant", 32'(HGRANT), 32'h1);
`endif
        chk("lk_rel.mastlock", 32'(HMASTLOCK), 32'd0);

        // Early termination: IDLE mid-INCR8 opens an arbitration point
        HTRANS  = 2'b00;
        HBUSREQ = 4'b0010;
        step();
        chk("et_take.grant", 32'(HGRANT), 32'h2);
        HBUSREQ = 4'b0100;
        HTRANS  = 2'b10;
        HBURST  = 3'b101;
        step();
        chk("et_b1.grant", 32'(HGRANT), 32'h2);
        HTRANS = 2'b11;
        step();
        chk("et_b2.grant", 32'(HGRANT), 32'h2);
        HTRANS = 2'b00;
        step();
        chk("et_idle.grant", 32'(HGRANT), 32'h4);

        // Asynchronous reset in the middle of a locked INCR16
        HLOCK  = 4'b0100;
        HTRANS = 2'b10;
        HBURST = 3'b111;
        step();
        chk_state("ar_pre", 4'b0100, 2'd2, 2'd1);
        chk("ar_pre.mastlock", 32'(HMASTLOCK), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_state("ar_rst", 4'b0001, 2'd0, 2'd0);
        chk("ar_rst.mastlock", 32'(HMASTLOCK), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0100;
        HTRANS  = 2'b01;
        step();
        chk("ar_post.grant", 32'(HGRANT), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Registered AHB bus arbiter that shares the single master-side address/data path among up to NUM_MASTERS requesters. It replaces the combinational fixed-priority grant with a clocked arbiter. The arbiter:
- hands over ownership only at legal AHB points (HREADY high, fixed-length burst complete, no lock held);
- drives the address-phase and data-phase owner indices used by the master multiplexor and the response steering.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters; 2..16.
- DEFAULT_MASTER, 0, master granted when nobody requests; 0..NUM_MASTERS-1.
- MW, $clog2(NUM_MASTERS), owner-index width (derived, not overridden).

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  muxed bus HTRANS (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
- HBURST  in  3  muxed bus HBURST.
- HREADY  in  1  muxed slave ready; a beat is accepted when HREADY=1.
- HGRANT  out  NUM_MASTERS  registered one-hot grant.
- HMASTER  out  MW  address-phase owner index.
- HMASTER_D  out  MW  data-phase owner index (HWDATA mux / HRDATA, HRESP steering).
- HMASTLOCK  out  1  current address phase is locked.

## Operation
- Owner index g = binary encoding of HGRANT.
- Burst length L from HBURST:
  - SINGLE and INCR: L=1.
  - INCR4 and WRAP4: L=4.
  - INCR8 and WRAP8: L=8.
  - INCR16 and WRAP16: L=16.
- beats_left is a 4-bit register. On each cycle with HREADY=1 it updates by case:
  - HTRANS=NONSEQ: load L-1.
  - HTRANS=SEQ: decrement, saturating at 0.
  - HTRANS=IDLE: clear to 0.
  - HTRANS=BUSY: hold.
- When HREADY=0, beats_left holds.
- r is the post-update value of beats_left for the current cycle.
- An arbitration point occurs when HREADY=1, r==0 and HLOCK[g]==0.
- At an arbitration point the next grant is chosen as follows:
  - If any HBUSREQ bit is set, grant the first requesting master found by searching cyclically upward from ptr. Then set ptr = (winner+1) mod NUM_MASTERS.
  - If no HBUSREQ bit is set, grant DEFAULT_MASTER and leave ptr unchanged.
- The grant may remain with the same master.
- Undefined-length INCR gets no hold. A master that needs atomicity uses HLOCK.
- When HREADY=1:
  - HMASTER <= g.
  - HMASTER_D <= HMASTER.
  - HMASTLOCK <= HLOCK[g].
- When HREADY=0, HMASTER, HMASTER_D and HMASTLOCK hold.
- Early burst termination (IDLE mid-burst) clears beats_left, so the next accepted cycle can be an arbitration point.

## Timing
- Reset values:
  - HGRANT = one-hot DEFAULT_MASTER.
  - HMASTER = HMASTER_D = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - beats_left = 0.
  - ptr = 0.
- Grant latency: a request sampled at an arbitration point edge appears on HGRANT after one cycle. HMASTER follows on the next HREADY=1 edge. HMASTER_D follows one accepted cycle after HMASTER.
- Grant changes only at arbitration points. During HREADY=0, HGRANT is frozen regardless of HBUSREQ.
- Lock: while HLOCK[g]=1, HGRANT is held even when other requesters are present and the burst is complete.
- Simultaneous requests resolve in the same cycle by ptr order. Only one HGRANT bit is ever set.
- Reset asserted mid-burst or mid-lock returns all state to reset values immediately (asynchronous).

## Configuration
- AHB_ARB_RR_EN defined: round-robin selection using ptr, as described above.
- AHB_ARB_RR_EN undefined: fixed priority, lowest requesting index wins. ptr logic is compiled out. All hold, lock, default-master and timing rules are unchanged.

## Test plan
- Reset: HRESETn=0 with DEFAULT_MASTER=0 → HGRANT=4'b0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0. These values hold after release with no requests.
- Round-robin (AHB_ARB_RR_EN): HBUSREQ=4'b1111, HTRANS=IDLE, HREADY=1 → HGRANT sequence 0001, 0010, 0100, 1000, 0001 on successive cycles. HMASTER lags HGRANT by one cycle.
- Burst hold: M1 owns and issues NONSEQ INCR4 then 3 SEQ with HREADY=1, with HBUSREQ[2]=1 throughout → HGRANT=0010 until the 4th beat is accepted, then 0100 on the next cycle.
- Wait states: same burst with HREADY=0 for 3 cycles on beat 2 → beats_left, HGRANT, HMASTER and HMASTER_D all frozen. Handover occurs 3 cycles later than in the burst-hold case.
- Lock: M2 owns with HLOCK[2]=1, HBUSREQ=4'b1111, SINGLE transfers → HGRANT stays 0100 and HMASTLOCK=1 after the first accepted cycle. After HLOCK[2] drops, the grant moves to M3 at the next arbitration point.
- Fixed priority (macro undefined): HBUSREQ=4'b1010 for 10 cycles → HGRANT=0010 throughout. With HBUSREQ=0, the grant returns to DEFAULT_MASTER.
